// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared definitions for the led_pwm_bank LED peripheral.
//   - mode_e      : per-channel output mode encodings
//   - MODE_LSB    : bit position of the 2-bit mode field in a channel register
//   - CTRL_*      : bit positions inside the control register
//   - chan_ctl_t  : timing/qualifier bundle broadcast from top to every channel
//   - ctrl_addr() : address of the control register for a given channel count
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  localparam int MODE_LSB       = 16;
  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_WFI_BLANK = 1;

  // Shared per-cycle qualifiers, identical for all channels.
  typedef struct packed {
    logic wrap;    // PWM period boundary: active duty reloads
    logic phase;   // blink phase (tied high when blink support is compiled out)
    logic freeze;  // hold led output
    logic blank;   // force led output low
    logic enable;  // global enable
  } chan_ctl_t;

  // Control register sits directly above the channel registers.
  function automatic int ctrl_addr(input int channels);
    return channels;
  endfunction

endpackage

// File: rtl/led_pwm_if.sv
// led_pwm_if: memory-mapped register bus of led_pwm_bank.
//   addr    : register select ($clog2(CHANNELS)+1 bits)
//   wr_en   : one-cycle write strobe
//   wr_data : write data
//   rd_data : registered readback of the register selected last cycle
// Modports: master (CPU/MMIO side), slave (peripheral side).
interface led_pwm_if #(
  parameter int CHANNELS = 8
);
  localparam int ADDR_W = $clog2(CHANNELS) + 1;

  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;

  modport master (output addr, wr_en, wr_data, input rd_data);
  modport slave  (input addr, wr_en, wr_data, output rd_data);
endinterface

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel of led_pwm_bank.
// Owns shadow duty, active duty, mode, the duty compare and the led register.
//   clk, reset : system clock, synchronous active-high reset
//   wr_sel     : write strobe already decoded for this channel
//   wr_duty    : duty field of the write data
//   wr_mode    : mode field of the write data
//   cnt        : shared PWM counter
//   ctl        : shared wrap / blink phase / freeze / blank / enable
//   duty_sh    : shadow duty (for readback)
//   mode       : current mode (for readback)
//   led        : registered pad drive
module led_pwm_channel import led_pwm_pkg::*; #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_sel,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  mode_e               wr_mode,
  input  logic [PWM_BITS-1:0] cnt,
  input  chan_ctl_t           ctl,
  output logic [PWM_BITS-1:0] duty_sh,
  output mode_e               mode,
  output logic                led
);

  logic [PWM_BITS-1:0] duty_act;
  logic                pwm_on;
  logic                raw;

  always_comb begin
    pwm_on = (cnt < duty_act);
    raw    = 1'b0;
    case (mode)
      MODE_OFF:   raw = 1'b0;
      MODE_ON:    raw = 1'b1;
      MODE_PWM:   raw = pwm_on;
      // phase is held high by the top when blink is compiled out, so this
      // degenerates to plain PWM there.
      MODE_BLINK: raw = pwm_on & ctl.phase;
      default:    raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_sh  <= '0;
      duty_act <= '0;
      mode     <= MODE_OFF;
      led      <= 1'b0;
    end else begin
      if (wr_sel) begin
        duty_sh <= wr_duty;
        mode    <= wr_mode;
      end
      // A write landing on the wrap cycle bypasses the shadow.
      if (ctl.wrap) duty_act <= wr_sel ? wr_duty : duty_sh;
      if (!ctl.freeze) led <= raw & ctl.enable & ~ctl.blank;
    end
  end

endmodule

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: multi-channel LED driver (off / on / PWM / blink per channel).
// Owns the prescaler, PWM counter, blink counter, control register and the
// readback mux; per-channel state lives in led_pwm_channel.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : led_pwm_if.slave register bus (addr, wr_en, wr_data, rd_data)
//   wfi        : processor wait-for-interrupt (freeze or blank the pads)
//   led_pad    : registered active-high LED drive
// Build option: LED_PWM_BLINK_EN enables the blink counter and mode 11 gating;
// without it mode 11 acts as mode 10 (still stored and read back as 11).
module led_pwm_bank import led_pwm_pkg::*; #(
  parameter int CHANNELS     = 8,
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE_DIV = 16,
  parameter int BLINK_BITS   = 20
) (
  input  logic                clk,
  input  logic                reset,
  led_pwm_if.slave            bus,
  input  logic                wfi,
  output logic [CHANNELS-1:0] led_pad
);

  localparam int ADDR_W = $clog2(CHANNELS) + 1;
  localparam int PS_W   = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_addr(CHANNELS));
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0]                    presc;
  logic [PWM_BITS-1:0]                cnt;
  logic [1:0]                         ctrl;
  logic                               freeze, blank, tick, wrap, phase;
  chan_ctl_t                          ctl;
  logic [CHANNELS-1:0]                wr_sel;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_sh;
  mode_e [CHANNELS-1:0]               mode;
  logic [31:0]                        rd_mux;

  assign freeze = wfi & ~ctrl[CTRL_WFI_BLANK];
  assign blank  = wfi &  ctrl[CTRL_WFI_BLANK];
  // Gating tick with freeze stops every counter and suppresses wrap.
  assign tick   = ~freeze & (presc == PS_LAST);
  assign wrap   = tick & (&cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      cnt   <= '0;
      ctrl  <= '0;
    end else begin
      if (!freeze) presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
      if (tick)    cnt   <= cnt + PWM_BITS'(1);
      if (bus.wr_en && bus.addr == CTRL_ADDR) ctrl <= bus.wr_data[1:0];
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [BLINK_BITS-1:0] blink;

  always_ff @(posedge clk) begin
    if (reset)     blink <= '0;
    else if (tick) blink <= blink + BLINK_BITS'(1);
  end

  assign phase = blink[BLINK_BITS-1];
`else
  assign phase = 1'b1;
`endif

  assign ctl = '{wrap: wrap, phase: phase, freeze: freeze, blank: blank,
                 enable: ctrl[CTRL_ENABLE]};

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign wr_sel[k] = bus.wr_en && (bus.addr == ADDR_W'(k));

    led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_sel  (wr_sel[k]),
      .wr_duty (bus.wr_data[PWM_BITS-1:0]),
      .wr_mode (mode_e'(bus.wr_data[MODE_LSB+:2])),
      .cnt     (cnt),
      .ctl     (ctl),
      .duty_sh (duty_sh[k]),
      .mode    (mode[k]),
      .led     (led_pad[k])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.addr == ADDR_W'(k)) begin
        rd_mux[PWM_BITS-1:0]   = duty_sh[k];
        rd_mux[MODE_LSB+:2]    = mode[k];
      end
    end
    if (bus.addr == CTRL_ADDR) rd_mux[1:0] = ctrl;
  end

  always_ff @(posedge clk) begin
    if (reset) bus.rd_data <= '0;
    else       bus.rd_data <= rd_mux;
  end

endmodule
